date_to_day_encoder: RTL and testbench
======================================

// Module: date_to_day_encoder
// PURPOSE
//  Inverse of the day-count-to-month/day path: user enters a calendar date (month, day)
//  with the two push buttons, block validates it against month lengths (leap-year aware)
//  and encodes it to a day-of-year number 1..366. Output feeds the day counter preload
//  and the HEX display muxes; month/day fields drive the date display while editing.
// PARAMETERS
//  DEBOUNCE_CYCLES  100_000    clocks a raw key level must stay stable to be accepted (10 ms @ 10 MHz)
//  REPEAT_CYCLES    3_000_000  hold time per auto-repeat increment (used only with DATE_ENC_AUTOREPEAT_EN)
// PORTS
//  ADC_CLK_10   in   1  system clock, 10 MHz
//  reset_n      in   1  asynchronous active-low reset
//  KEY          in   2  raw push buttons, active-low; KEY[0]=increment, KEY[1]=advance/commit
//  leap         in   1  1 = leap year (Feb has 29 days); from SW
//  month        out  4  edited month, 1..12
//  day          out  5  edited day, 1..month length
//  field_sel    out  1  0 = editing month, 1 = editing day
//  busy         out  1  high while in CONVERT
//  day_of_year  out  9  encoded result, 1..366; holds until next conversion
//  doy_valid    out  1  one-cycle pulse when day_of_year updates
// BEHAVIOUR
//  Reset: state=SET_MONTH, month=1, day=1, field_sel=0, busy=0, day_of_year=1, doy_valid=0;
//   debouncers load "released" (1); no event is generated on reset release.
//  Keys: two-FF synchroniser per key, then debouncer: level accepted after DEBOUNCE_CYCLES
//   consecutive equal samples. press event = accepted 1->0 transition, exactly one cycle.
//   Glitches shorter than DEBOUNCE_CYCLES produce no event.
//  Simultaneous inc+adv events in one cycle: adv processed, inc dropped.
//  Month length: 31,28/29,31,30,31,30,31,31,30,31,30,31 (Feb uses leap).
//  FSM:
//   SET_MONTH: inc -> month+1, 12 wraps to 1; day clamped to new month length same edge.
//              adv -> SET_DAY (field_sel=1).
//   SET_DAY:   inc -> day+1, month length wraps to 1. adv -> CONVERT.
//   CONVERT:   entry loads acc=day, idx=1, busy=1. Each cycle: if idx==month then
//              day_of_year<=acc, doy_valid=1 next cycle, -> DONE; else acc+=len(idx), idx+=1.
//              Latency: doy_valid high on the month-th clock after CONVERT entry
//              (Jan: 1, Dec: 12). Key events during CONVERT are discarded.
//   DONE:      busy=0. adv -> SET_MONTH (field_sel=0), month/day retained; inc ignored.
//  leap change in any state: if month==2 and day==29 and leap falls, day->28 next cycle.
//   leap sampled for the whole CONVERT from its value at CONVERT entry (latched).
//  Arithmetic: acc 9 bits unsigned, never exceeds 366; no overflow path.
//  Reset asserted mid-CONVERT: all outputs return to reset values, no doy_valid pulse.
// CONFIGURATION
//  DATE_ENC_AUTOREPEAT_EN defined: KEY[0] held (accepted low) generates an extra inc
//   event every REPEAT_CYCLES after the initial press event until release; repeat
//   counter clears on release and on reset; repeats suppressed outside SET_MONTH/SET_DAY.
//  Not defined: exactly one inc event per press regardless of hold time; REPEAT_CYCLES unused.
// TESTING  (sim with DEBOUNCE_CYCLES=4, REPEAT_CYCLES=20)
//  1 Reset, idle 10 clk -> month=1 day=1 field_sel=0 busy=0 day_of_year=1 doy_valid=0.
//  2 inc x2 (month=3), adv, adv, leap=0 -> day_of_year=60, single doy_valid pulse 3 clk
//    after CONVERT entry; adv, adv, adv with leap=1 -> 61.
//  3 month=12 day=31: leap=0 -> 365 (doy_valid 12 clk after entry); leap=1 -> 366.
//  4 Wrap/clamp: month 12 +inc -> 1; Jan day 31 +inc -> 1; day=31 then back to
//    SET_MONTH, inc to month 2 -> day=28 (leap=0) / 29 (leap=1); Feb 29 with leap 1->0 -> 28.
//  5 KEY[0] low 3 clk -> no change; both keys pressed same cycle in SET_MONTH -> field_sel=1,
//    month unchanged; reset_n low during CONVERT of month 12 -> reset values, no doy_valid.
//  6 Macro defined: KEY[0] held 70 clk after acceptance in SET_DAY -> day+4 (1 press + 3
//    repeats); macro undefined, same stimulus -> day+1.

Source files
------------

// File: rtl/date_to_day_encoder.sv
// Debounced two-key month/day editor that encodes the entered date as a day-of-year number 1..366.
// Latency: key event 2 sync + DEBOUNCE_CYCLES clocks; doy_valid on the month-th clock after CONVERT entry.
// No backpressure: key events arriving during CONVERT are dropped. DATE_ENC_AUTOREPEAT_EN enables KEY[0] auto-repeat.
module date_to_day_encoder #(
    parameter int DEBOUNCE_CYCLES = 100_000,
    parameter int REPEAT_CYCLES   = 3_000_000
) (
    input  logic       ADC_CLK_10,
    input  logic       reset_n,
    input  logic [1:0] KEY,
    input  logic       leap,
    output logic [3:0] month,
    output logic [4:0] day,
    output logic       field_sel,
    output logic       busy,
    output logic [8:0] day_of_year,
    output logic       doy_valid
);

    typedef enum logic [1:0] {SET_MONTH, SET_DAY, CONVERT, DONE} state_t;

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]      key_sync1;
    logic [1:0]      key_sync2;
    logic [1:0]      key_lvl;
    logic [1:0]      key_lvl_q;
    logic [DB_W-1:0] db_cnt [2];
    logic [1:0]      key_press;
    logic            rpt_evt;
    logic            inc_evt;
    logic            adv_evt;

    state_t      state, state_nxt;
    logic [3:0]  month_nxt;
    logic [4:0]  day_nxt;
    logic [4:0]  day_cur;
    logic [3:0]  month_inc;
    logic [8:0]  acc, acc_nxt;
    logic [3:0]  idx, idx_nxt;
    logic        leap_lat, leap_lat_nxt;
    logic [8:0]  doy_nxt;
    logic        doy_vld_nxt;

    function automatic logic [4:0] month_len(input logic [3:0] m, input logic lp);
        case (m)
            4'd2:                     month_len = lp ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11:  month_len = 5'd30;
            default:                  month_len = 5'd31;
        endcase
    endfunction

    // Synchroniser and debouncer; everything resets to "released" so reset release is silent
    always_ff @(posedge ADC_CLK_10 or negedge reset_n) begin
        if (!reset_n) begin
            key_sync1 <= 2'b11;
            key_sync2 <= 2'b11;
            key_lvl   <= 2'b11;
            key_lvl_q <= 2'b11;
            for (int k = 0; k < 2; k++) db_cnt[k] <= '0;
        end else begin
            key_sync1 <= KEY;
            key_sync2 <= key_sync1;
            key_lvl_q <= key_lvl;
            for (int k = 0; k < 2; k++) begin
                if (key_sync2[k] == key_lvl[k]) begin
                    db_cnt[k] <= '0;
                end else if (db_cnt[k] == DB_MAX) begin
                    key_lvl[k] <= key_sync2[k];
                    db_cnt[k]  <= '0;
                end else begin
                    db_cnt[k] <= db_cnt[k] + 1'b1;
                end
            end
        end
    end

    assign key_press = key_lvl_q & ~key_lvl;

`ifdef DATE_ENC_AUTOREPEAT_EN
    localparam int RPT_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [RPT_W-1:0] RPT_MAX = RPT_W'(REPEAT_CYCLES - 1);

    logic [RPT_W-1:0] rpt_cnt;
    logic             rpt_pulse;

    always_ff @(posedge ADC_CLK_10 or negedge reset_n) begin
        if (!reset_n) begin
            rpt_cnt   <= '0;
            rpt_pulse <= 1'b0;
        end else if (key_lvl[0]) begin
            rpt_cnt   <= '0;
            rpt_pulse <= 1'b0;
        end else if (rpt_cnt == RPT_MAX) begin
            rpt_cnt   <= '0;
            rpt_pulse <= 1'b1;
        end else begin
            rpt_cnt   <= rpt_cnt + 1'b1;
            rpt_pulse <= 1'b0;
        end
    end

    assign rpt_evt = rpt_pulse && (state == SET_MONTH || state == SET_DAY);
`else
    logic unused_rpt_cycles;
    assign unused_rpt_cycles = ^REPEAT_CYCLES;
    assign rpt_evt = 1'b0;
`endif

    assign inc_evt = key_press[0] | rpt_evt;
    assign adv_evt = key_press[1];

    always_ff @(posedge ADC_CLK_10 or negedge reset_n) begin
        if (!reset_n) begin
            state       <= SET_MONTH;
            month       <= 4'd1;
            day         <= 5'd1;
            acc         <= 9'd0;
            idx         <= 4'd1;
            leap_lat    <= 1'b0;
            day_of_year <= 9'd1;
            doy_valid   <= 1'b0;
        end else begin
            state       <= state_nxt;
            month       <= month_nxt;
            day         <= day_nxt;
            acc         <= acc_nxt;
            idx         <= idx_nxt;
            leap_lat    <= leap_lat_nxt;
            day_of_year <= doy_nxt;
            doy_valid   <= doy_vld_nxt;
        end
    end

    assign month_inc = (month == 4'd12) ? 4'd1 : month + 4'd1;
    // Feb 29 is only legal while leap is high; pull it back as soon as leap drops
    assign day_cur   = (month == 4'd2 && day == 5'd29 && !leap) ? 5'd28 : day;

    always_comb begin
        state_nxt    = state;
        month_nxt    = month;
        day_nxt      = day_cur;
        acc_nxt      = acc;
        idx_nxt      = idx;
        leap_lat_nxt = leap_lat;
        doy_nxt      = day_of_year;
        doy_vld_nxt  = 1'b0;
        case (state)
            SET_MONTH: begin
                if (adv_evt) begin
                    state_nxt = SET_DAY;
                end else if (inc_evt) begin
                    month_nxt = month_inc;
                    if (day_cur > month_len(month_inc, leap))
                        day_nxt = month_len(month_inc, leap);
                end
            end
            SET_DAY: begin
                if (adv_evt) begin
                    state_nxt    = CONVERT;
                    acc_nxt      = {4'd0, day_cur};
                    idx_nxt      = 4'd1;
                    leap_lat_nxt = leap;
                end else if (inc_evt) begin
                    day_nxt = (day_cur >= month_len(month, leap)) ? 5'd1 : day_cur + 5'd1;
                end
            end
            CONVERT: begin
                if (idx == month) begin
                    doy_nxt     = acc;
                    doy_vld_nxt = 1'b1;
                    state_nxt   = DONE;
                end else begin
                    acc_nxt = acc + {4'd0, month_len(idx, leap_lat)};
                    idx_nxt = idx + 4'd1;
                end
            end
            DONE: begin
                if (adv_evt) state_nxt = SET_MONTH;
            end
            default: state_nxt = SET_MONTH;
        endcase
    end

    assign field_sel = (state != SET_MONTH);
    assign busy      = (state == CONVERT);

endmodule

// File: tb/tb_date_to_day_encoder.sv
// Scoreboarded bench for date_to_day_encoder with a calendar-level reference model.
`timescale 1ns/1ps
module tb_date_to_day_encoder;

    localparam int DB = 4;
    localparam int RP = 20;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] KEY = 2'b11;
    logic       leap = 1'b0;
    logic [3:0] month;
    logic [4:0] day;
    logic       field_sel;
    logic       busy;
    logic [8:0] day_of_year;
    logic       doy_valid;

    always #50 clk = ~clk;

    date_to_day_encoder #(.DEBOUNCE_CYCLES(DB), .REPEAT_CYCLES(RP)) dut (
        .ADC_CLK_10 (clk),
        .reset_n    (reset_n),
        .KEY        (KEY),
        .leap       (leap),
        .month      (month),
        .day        (day),
        .field_sel  (field_sel),
        .busy       (busy),
        .day_of_year(day_of_year),
        .doy_valid  (doy_valid)
    );

    typedef struct { int doy; int lat; } exp_t;
    exp_t sb[$];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int conv_start = 0;
    bit busy_prev = 1'b0;

    // Model state: mode 0 = month edit, 1 = day edit, 3 = result shown
    int m_mon = 1;
    int m_day = 1;
    int m_mode = 0;
    int cum_days [13] = '{0, 0, 31, 59, 90, 120, 151, 181, 212, 243, 273, 304, 334};

    function automatic int mlen(input int m, input bit lp);
        if (m == 2) return lp ? 29 : 28;
        if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
        return 31;
    endfunction

    function automatic int doy_of(input int m, input int d, input bit lp);
        return cum_days[m] + d + ((lp && m > 2) ? 1 : 0);
    endfunction

    task automatic chk(input string name, input int act, input int exp_v);
        vectors++;
        if (act != exp_v) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    task automatic chk_fields(input string tag);
        chk({tag, ".month"}, month, m_mon);
        chk({tag, ".day"}, day, m_day);
        chk({tag, ".field_sel"}, field_sel, (m_mode != 0) ? 1 : 0);
        chk({tag, ".busy"}, busy, 0);
    endtask

    task automatic chk_reset(input string tag);
        chk_fields(tag);
        chk({tag, ".doy"}, day_of_year, 1);
        chk({tag, ".doy_valid"}, doy_valid, 0);
    endtask

    task automatic model_inc();
        if (m_mode == 0) begin
            m_mon = (m_mon % 12) + 1;
            if (m_day > mlen(m_mon, leap)) m_day = mlen(m_mon, leap);
        end else if (m_mode == 1) begin
            m_day = (m_day >= mlen(m_mon, leap)) ? 1 : m_day + 1;
        end
    endtask

    task automatic model_adv();
        case (m_mode)
            0: m_mode = 1;
            1: begin
                sb.push_back('{doy_of(m_mon, m_day, leap), m_mon});
                m_mode = 3;
            end
            default: m_mode = 0;
        endcase
    endtask

    task automatic press(input bit inc, input bit adv, input int hold, input int n_inc, input string tag);
        if (adv) model_adv();
        else if (inc) for (int i = 0; i < n_inc; i++) model_inc();
        @(negedge clk);
        KEY = {~adv, ~inc};
        repeat (hold) @(negedge clk);
        KEY = 2'b11;
        repeat (14) @(negedge clk);
        chk_fields(tag);
    endtask

    task automatic set_leap(input bit v);
        @(negedge clk);
        leap = v;
        if (m_mon == 2 && m_day == 29 && !v) m_day = 28;
        repeat (3) @(negedge clk);
    endtask

    // Drive the editor to (m, d) with leap value lp; ends in day-edit mode
    task automatic goto_date(input int m, input int d, input bit lp);
        if (m_mode == 1) press(0, 1, 10, 0, "nav.conv");
        if (m_mode == 3) press(0, 1, 10, 0, "nav.back");
        set_leap(lp);
        while (m_mon != m) press(1, 0, 10, 1, "nav.mon");
        press(0, 1, 10, 0, "nav.adv");
        while (m_day != d) press(1, 0, 10, 1, "nav.day");
    endtask

    // Monitor: every doy_valid pulse must match the oldest queued conversion
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (busy && !busy_prev) conv_start = cyc;
            busy_prev = busy;
            if (doy_valid) begin
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_doy_valid: got pulse with day_of_year=%0d, expected none", day_of_year);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("sb.doy", day_of_year, e.doy);
                    chk("sb.latency", cyc - conv_start, e.lat);
                    chk("sb.busy_in_done", busy, 0);
                end
            end
        end
    end

    initial begin
        #(100 * 60000);
        miscompares++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "watchdog");
    end

    initial begin
        int tm, td;
        bit tl;
        int n_hold;

        // Reset and idle
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        chk_reset("reset");

        // March 1 with and without leap
        press(1, 0, 10, 1, "t2.inc1");
        press(1, 0, 10, 1, "t2.inc2");
        press(0, 1, 10, 0, "t2.adv_day");
        press(0, 1, 10, 0, "t2.conv60");
        press(0, 1, 10, 0, "t2.back");
        press(0, 1, 10, 0, "t2.adv_day2");
        set_leap(1'b1);
        press(0, 1, 10, 0, "t2.conv61");
        chk("t2.doy_hold", day_of_year, 61);

        // Dec 31 both ways
        goto_date(12, 31, 1'b0);
        press(0, 1, 10, 0, "t3.conv365");
        press(0, 1, 10, 0, "t3.back");
        press(0, 1, 10, 0, "t3.adv_day");
        set_leap(1'b1);
        press(0, 1, 10, 0, "t3.conv366");

        // Wrap and clamp
        press(0, 1, 10, 0, "t4.back");
        set_leap(1'b0);
        press(1, 0, 10, 1, "t4.mon_wrap");
        chk("t4.mon_wrap_is1", month, 1);
        press(1, 0, 10, 1, "t4.feb_clamp28");
        chk("t4.feb_day28", day, 28);
        goto_date(1, 31, 1'b1);
        press(1, 0, 10, 1, "t4.day_wrap");
        chk("t4.day_wrap_is1", day, 1);
        while (m_day != 31) press(1, 0, 10, 1, "t4.day_up");
        press(0, 1, 10, 0, "t4.conv31");
        press(0, 1, 10, 0, "t4.back2");
        press(1, 0, 10, 1, "t4.feb_clamp29");
        chk("t4.feb_day29", day, 29);
        press(0, 1, 10, 0, "t4.adv_day");
        set_leap(1'b0);
        chk_fields("t4.leap_fall");
        chk("t4.leap_fall_day28", day, 28);

        // Glitch, simultaneous keys, reset mid-conversion
        @(negedge clk);
        KEY[0] = 1'b0;
        repeat (3) @(negedge clk);
        KEY[0] = 1'b1;
        repeat (12) @(negedge clk);
        chk_fields("t5.glitch");
        press(0, 1, 10, 0, "t5.conv");
        press(0, 1, 10, 0, "t5.back");
        press(1, 1, 10, 0, "t5.both");
        goto_date(12, 15, 1'b0);
        @(negedge clk);
        KEY[1] = 1'b0;
        for (int i = 0; i < 40 && !busy; i++) @(negedge clk);
        chk("t5.busy_seen", busy, 1);
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        KEY = 2'b11;
        m_mon = 1; m_day = 1; m_mode = 0;
        @(negedge clk);
        chk_reset("t5.rst_asserted");
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        chk_reset("t5.rst_released");

        // Held increment: one press, plus repeats only when the feature is built in
        press(0, 1, 10, 0, "t6.adv_day");
`ifdef DATE_ENC_AUTOREPEAT_EN
        n_hold = 4;
`else
        n_hold = 1;
`endif
        press(1, 0, 76, n_hold, "t6.hold");

        // Random dates against the calendar model
        for (int it = 0; it < 10; it++) begin
            tm = $urandom_range(1, 12);
            tl = 1'($urandom_range(0, 1));
            td = $urandom_range(1, mlen(tm, tl));
            goto_date(tm, td, tl);
            press(0, 1, 10, 0, "rand.conv");
        end

        repeat (30) @(negedge clk);
        chk("sb.drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
